// File: rtl/inst_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: geometry defaults
// and the refill FSM state encoding.
package inst_cache_pkg;

  localparam int DEF_INDEX_BITS  = 4;
  localparam int DEF_OFFSET_BITS = 2;

  typedef enum logic [0:0] {
    IC_IDLE   = 1'b0,
    IC_REFILL = 1'b1
  } ic_state_e;

  // Word-aligned base address of the line containing addr.
  function automatic logic [31:0] line_base(input logic [31:0] addr, input int offset_bits);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << (offset_bits + 2);
    return addr & mask;
  endfunction

endpackage

// File: rtl/inst_cache_array.sv
// Valid/tag/data storage for the instruction cache: combinational read by
// (index, offset), synchronous single-word write, line allocate and valid set.
module icache_array
  import inst_cache_pkg::*;
#(
  parameter int INDEX_BITS  = DEF_INDEX_BITS,
  parameter int OFFSET_BITS = DEF_OFFSET_BITS,
  parameter int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS - 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [INDEX_BITS-1:0]  i_rd_index,
  input  logic [OFFSET_BITS-1:0] i_rd_offset,
  output logic                   o_rd_valid,
  output logic [TAG_BITS-1:0]    o_rd_tag,
  output logic [31:0]            o_rd_word,
  input  logic                   i_alloc_en,
  input  logic [INDEX_BITS-1:0]  i_alloc_index,
  input  logic [TAG_BITS-1:0]    i_alloc_tag,
  input  logic                   i_wr_en,
  input  logic [INDEX_BITS-1:0]  i_wr_index,
  input  logic [OFFSET_BITS-1:0] i_wr_offset,
  input  logic [31:0]            i_wr_data,
  input  logic                   i_valid_set
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << OFFSET_BITS;

  logic [LINES-1:0]    r_valid;
  logic [TAG_BITS-1:0] r_tag  [LINES];
  logic [31:0]         r_data [LINES*WORDS];

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_word  = r_data[{i_rd_index, i_rd_offset}];

  // Allocation invalidates the line until its final word marks it valid again.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
    end else if (i_alloc_en) begin
      r_valid[i_alloc_index] <= 1'b0;
    end else if (i_wr_en && i_valid_set) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_alloc_en) begin
      r_tag[i_alloc_index] <= i_alloc_tag;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_data[{i_wr_index, i_wr_offset}] <= i_wr_data;
    end
  end

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: registered fetch response,
// combinational lookup port, and word-by-word line refill from memory.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int INDEX_BITS  = DEF_INDEX_BITS,
  parameter int OFFSET_BITS = DEF_OFFSET_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        fetch_enable,
  input  logic [31:0] cache_pc,
  output logic        cache_valid,
  output logic [31:0] cache_inst,
  output logic        hit_valid,
  output logic [31:0] hit_inst,
  input  logic        should_reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_data
);

  localparam int TAG_LSB  = INDEX_BITS + OFFSET_BITS + 2;
  localparam int TAG_BITS = 32 - TAG_LSB;
  localparam logic [OFFSET_BITS-1:0] LAST_WORD = '1;

  ic_state_e               r_state;
  logic                    r_cache_valid;
  logic [31:0]             r_cache_inst;
  logic                    r_mem_req;
  logic [31:0]             r_mem_addr;
  logic [OFFSET_BITS-1:0]  r_count;
  logic [INDEX_BITS-1:0]   r_miss_index;

  logic [OFFSET_BITS-1:0]  w_pc_offset;
  logic [INDEX_BITS-1:0]   w_pc_index;
  logic [TAG_BITS-1:0]     w_pc_tag;
  logic                    w_rd_valid;
  logic [TAG_BITS-1:0]     w_rd_tag;
  logic [31:0]             w_rd_word;
  logic                    w_hit;
  logic                    w_live;
  logic                    w_alloc;
  logic                    w_wr_en;
  logic                    w_last;
  logic                    w_unused;

  assign w_pc_offset = cache_pc[OFFSET_BITS+1:2];
  assign w_pc_index  = cache_pc[TAG_LSB-1:OFFSET_BITS+2];
  assign w_pc_tag    = cache_pc[31:TAG_LSB];
  assign w_unused    = ^cache_pc[1:0];

  assign w_hit  = w_rd_valid && (w_rd_tag == w_pc_tag);
  // A flush or a stalled pipeline blocks every array update in that cycle.
  assign w_live  = rdy && !should_reset;
  assign w_alloc = w_live && (r_state == IC_IDLE) && fetch_enable && !w_hit;
  assign w_wr_en = w_live && (r_state == IC_REFILL) && mem_valid;
  assign w_last  = (r_count == LAST_WORD);

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .OFFSET_BITS(OFFSET_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rd_index   (w_pc_index),
    .i_rd_offset  (w_pc_offset),
    .o_rd_valid   (w_rd_valid),
    .o_rd_tag     (w_rd_tag),
    .o_rd_word    (w_rd_word),
    .i_alloc_en   (w_alloc),
    .i_alloc_index(w_pc_index),
    .i_alloc_tag  (w_pc_tag),
    .i_wr_en      (w_wr_en),
    .i_wr_index   (r_miss_index),
    .i_wr_offset  (r_count),
    .i_wr_data    (mem_data),
    .i_valid_set  (w_last)
  );

  assign hit_valid   = w_hit;
  assign hit_inst    = w_rd_word;
  assign cache_valid = r_cache_valid;
  assign cache_inst  = r_cache_inst;
  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;

  // Lookup/refill FSM with all fetch and memory-port outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IC_IDLE;
      r_cache_valid <= 1'b0;
      r_cache_inst  <= 32'h0000_0000;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= 32'h0000_0000;
      r_count       <= '0;
      r_miss_index  <= '0;
    end else if (rdy) begin
      if (should_reset) begin
        r_state       <= IC_IDLE;
        r_cache_valid <= 1'b0;
        r_mem_req     <= 1'b0;
      end else begin
        case (r_state)
          IC_IDLE: begin
            if (fetch_enable && w_hit) begin
              r_cache_valid <= 1'b1;
              r_cache_inst  <= w_rd_word;
            end else if (fetch_enable) begin
              r_cache_valid <= 1'b0;
              r_miss_index  <= w_pc_index;
              r_count       <= '0;
              r_mem_req     <= 1'b1;
              r_mem_addr    <= line_base(cache_pc, OFFSET_BITS);
              r_state       <= IC_REFILL;
            end else begin
              r_cache_valid <= 1'b0;
            end
          end
          IC_REFILL: begin
            r_cache_valid <= 1'b0;
            if (mem_valid) begin
              r_count    <= r_count + 1'b1;
              r_mem_addr <= r_mem_addr + 32'd4;
              if (w_last) begin
                r_mem_req <= 1'b0;
                r_state   <= IC_IDLE;
              end
            end
          end
          default: begin
            r_state   <= IC_IDLE;
            r_mem_req <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Directed plus randomized bench for inst_cache against a line-level cache model.
module tb_inst_cache;

  logic        clk = 1'b0;
  logic        rst, rdy, fetch_enable, should_reset, mem_valid;
  logic [31:0] cache_pc, mem_data;
  logic        cache_valid, hit_valid, mem_req;
  logic [31:0] cache_inst, hit_inst, mem_addr;

  int total = 0;
  int bad   = 0;

  bit          ref_valid [16];
  logic [23:0] ref_tag   [16];
  logic [31:0] ref_data  [16][4];

  always #5 clk = ~clk;

  inst_cache dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .fetch_enable(fetch_enable),
    .cache_pc    (cache_pc),
    .cache_valid (cache_valid),
    .cache_inst  (cache_inst),
    .hit_valid   (hit_valid),
    .hit_inst    (hit_inst),
    .should_reset(should_reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_valid   (mem_valid),
    .mem_data    (mem_data)
  );

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 32'd16) % 32'd16);
  endfunction

  function automatic int off_of(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'd4);
  endfunction

  function automatic logic [23:0] tag_of(input logic [31:0] pc);
    return 24'(pc / 32'd256);
  endfunction

  function automatic bit ref_hit(input logic [31:0] pc);
    return ref_valid[idx_of(pc)] && (ref_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  // Backing memory contents: 0x10 -> 0xAAAA0001, 0x14 -> 0xAAAA0002, ...
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return 32'hAAAA_0000 + (a / 32'd4) - 32'd3;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h required=%h", name, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_hit();
    chk("hit_valid", {31'd0, hit_valid}, {31'd0, ref_hit(cache_pc)});
    if (ref_hit(cache_pc))
      chk("hit_inst", hit_inst, ref_data[idx_of(cache_pc)][off_of(cache_pc)]);
  endtask

  task automatic ref_alloc(input logic [31:0] pc);
    ref_valid[idx_of(pc)] = 1'b0;
    ref_tag[idx_of(pc)]   = tag_of(pc);
  endtask

  // Serve words first..3 of pc's line with random stall/ignored-input cycles.
  task automatic do_refill(input logic [31:0] pc, input int first);
    logic [31:0] base;
    int          i;
    int          gaps;
    base = pc & 32'hFFFF_FFF0;
    i    = idx_of(pc);
    for (int w = first; w < 4; w++) begin
      gaps = int'($urandom_range(0, 2));
      for (int g = 0; g < gaps; g++) begin
        rdy          = 1'($urandom_range(0, 1));
        fetch_enable = 1'($urandom_range(0, 1));
        cache_pc     = $urandom;
        mem_valid    = 1'b0;
        cyc();
        chk("gap_mem_req", {31'd0, mem_req}, 32'd1);
        chk("gap_mem_addr", mem_addr, base + 32'(4 * w));
        chk("gap_cache_valid", {31'd0, cache_valid}, 32'd0);
        check_hit();
      end
      rdy          = 1'b1;
      fetch_enable = 1'b1;
      cache_pc     = pc;
      mem_valid    = 1'b1;
      mem_data     = mem_fn(base + 32'(4 * w));
      cyc();
      ref_data[i][w] = mem_fn(base + 32'(4 * w));
      mem_valid      = 1'b0;
      if (w == 3) begin
        ref_valid[i] = 1'b1;
        chk("last_mem_req", {31'd0, mem_req}, 32'd0);
      end else begin
        chk("word_mem_req", {31'd0, mem_req}, 32'd1);
        chk("word_mem_addr", mem_addr, base + 32'(4 * (w + 1)));
      end
      chk("word_cache_valid", {31'd0, cache_valid}, 32'd0);
    end
    cyc();
    chk("refill_cache_valid", {31'd0, cache_valid}, 32'd1);
    chk("refill_cache_inst", cache_inst, ref_data[i][off_of(pc)]);
    check_hit();
  endtask

  task automatic do_fetch(input logic [31:0] pc);
    bit h;
    h            = ref_hit(pc);
    rdy          = 1'b1;
    fetch_enable = 1'b1;
    cache_pc     = pc;
    mem_valid    = 1'b0;
    cyc();
    if (h) begin
      chk("hit_cache_valid", {31'd0, cache_valid}, 32'd1);
      chk("hit_cache_inst", cache_inst, ref_data[idx_of(pc)][off_of(pc)]);
      chk("hit_mem_req", {31'd0, mem_req}, 32'd0);
    end else begin
      chk("miss_cache_valid", {31'd0, cache_valid}, 32'd0);
      chk("miss_mem_req", {31'd0, mem_req}, 32'd1);
      chk("miss_mem_addr", mem_addr, pc & 32'hFFFF_FFF0);
      ref_alloc(pc);
      do_refill(pc, 0);
    end
  endtask

  initial begin
    logic [31:0] pc;

    for (int k = 0; k < 16; k++) ref_valid[k] = 1'b0;
    rst = 1'b1; rdy = 1'b1; fetch_enable = 1'b0; should_reset = 1'b0;
    mem_valid = 1'b0; mem_data = 32'h0; cache_pc = 32'h0;
    cyc();
    cyc();
    chk("rst_cache_valid", {31'd0, cache_valid}, 32'd0);
    chk("rst_cache_inst", cache_inst, 32'h0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_hit_valid", {31'd0, hit_valid}, 32'd0);
    rst = 1'b0;

    // Cold miss then hits within the same line.
    do_fetch(32'h0000_0010);
    chk("cold_inst", cache_inst, 32'hAAAA_0001);
    chk("cold_hit_valid", {31'd0, hit_valid}, 32'd1);
    do_fetch(32'h0000_0018);
    chk("hit18_inst", cache_inst, 32'hAAAA_0003);
    cache_pc = 32'h0000_0014;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("held_valid", {31'd0, cache_valid}, 32'd1);
      chk("held_inst", cache_inst, 32'hAAAA_0002);
    end

    // rdy low freezes the response even with the request dropped.
    rdy = 1'b0; fetch_enable = 1'b0;
    cyc();
    chk("rdy_idle_valid", {31'd0, cache_valid}, 32'd1);
    rdy = 1'b1;
    cyc();
    chk("idle_no_fetch", {31'd0, cache_valid}, 32'd0);

    // Flush beats a hitting fetch.
    fetch_enable = 1'b1; should_reset = 1'b1;
    cyc();
    chk("flush_hit_valid", {31'd0, cache_valid}, 32'd0);
    should_reset = 1'b0;

    // Conflict eviction on index 1.
    do_fetch(32'h0000_0110);
    fetch_enable = 1'b0; cache_pc = 32'h0000_0010;
    cyc();
    chk("evicted_hit_valid", {31'd0, hit_valid}, 32'd0);
    do_fetch(32'h0000_0010);

    // Flush after two refill words; line stays invalid, full refill follows.
    fetch_enable = 1'b1; cache_pc = 32'h0000_0100;
    cyc();
    chk("f1_mem_addr", mem_addr, 32'h0000_0100);
    ref_alloc(32'h0000_0100);
    for (int w = 0; w < 2; w++) begin
      mem_valid = 1'b1; mem_data = mem_fn(32'h100 + 32'(4 * w));
      cyc();
      ref_data[0][w] = mem_data;
    end
    should_reset = 1'b1; mem_data = 32'hDEAD_BEEF;
    cyc();
    chk("f1_mem_req", {31'd0, mem_req}, 32'd0);
    chk("f1_cache_valid", {31'd0, cache_valid}, 32'd0);
    should_reset = 1'b0; mem_valid = 1'b0; fetch_enable = 1'b0;
    cyc();
    chk("f1_hit_valid", {31'd0, hit_valid}, 32'd0);
    chk("f1_idle_req", {31'd0, mem_req}, 32'd0);
    do_fetch(32'h0000_0100);

    // Flush coinciding with the final word leaves the line invalid.
    fetch_enable = 1'b1; cache_pc = 32'h0000_0200;
    cyc();
    ref_alloc(32'h0000_0200);
    for (int w = 0; w < 3; w++) begin
      mem_valid = 1'b1; mem_data = mem_fn(32'h200 + 32'(4 * w));
      cyc();
      ref_data[0][w] = mem_data;
    end
    should_reset = 1'b1; mem_data = mem_fn(32'h20C);
    cyc();
    should_reset = 1'b0; mem_valid = 1'b0; fetch_enable = 1'b0;
    chk("f2_mem_req", {31'd0, mem_req}, 32'd0);
    chk("f2_hit_valid", {31'd0, hit_valid}, 32'd0);
    cyc();
    chk("f2_cache_valid", {31'd0, cache_valid}, 32'd0);

    // rdy low mid-refill holds everything, even a flush and new requests.
    fetch_enable = 1'b1; cache_pc = 32'h0000_0300;
    cyc();
    ref_alloc(32'h0000_0300);
    mem_valid = 1'b1; mem_data = mem_fn(32'h300);
    cyc();
    ref_data[0][0] = mem_data;
    mem_valid = 1'b0;
    rdy = 1'b0; should_reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      fetch_enable = 1'($urandom_range(0, 1));
      cache_pc     = $urandom;
      cyc();
      chk("stall_mem_addr", mem_addr, 32'h0000_0304);
      chk("stall_mem_req", {31'd0, mem_req}, 32'd1);
      chk("stall_cache_valid", {31'd0, cache_valid}, 32'd0);
    end
    rdy = 1'b1; should_reset = 1'b0;
    do_refill(32'h0000_0300, 1);

    // Random fetches over a small address space to mix hits, misses and conflicts.
    for (int n = 0; n < 30; n++) begin
      pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4) |
           (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      do_fetch(pc);
      if ($urandom_range(0, 3) == 0) begin
        fetch_enable = 1'b0;
        cyc();
        chk("rand_idle_valid", {31'd0, cache_valid}, 32'd0);
        check_hit();
      end
    end

    // Reset during a refill clears the port and every line.
    fetch_enable = 1'b1; cache_pc = 32'h0000_0400;
    cyc();
    rst = 1'b1;
    cyc();
    for (int k = 0; k < 16; k++) ref_valid[k] = 1'b0;
    chk("rst2_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst2_mem_addr", mem_addr, 32'h0);
    chk("rst2_cache_valid", {31'd0, cache_valid}, 32'd0);
    chk("rst2_cache_inst", cache_inst, 32'h0);
    rst = 1'b0; fetch_enable = 1'b0; cache_pc = 32'h0000_0014;
    cyc();
    chk("rst2_hit_valid", {31'd0, hit_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
